// File: rtl/crc8_frame_appender.sv
// crc8_frame_appender -- TX-side framing stage that appends a CRC-8 beat.
//
// A byte stream goes through a one-entry output register. CRC-8 (poly 0x07,
// MSB-first) is accumulated over every accepted payload byte. After the byte
// flagged s_last, one extra beat is inserted that carries (crc ^ XOR_OUT) with
// m_last set. The CRC register then returns to INIT for the next frame.
//
// Parameters:
//   INIT     CRC register value at reset and at the start of each frame
//   XOR_OUT  value XORed onto the accumulated CRC before it is emitted
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   s_data     payload byte in
//   s_valid    upstream byte valid
//   s_last     s_data is the final payload byte of the frame
//   s_ready    stage accepts a byte this cycle (combinational from m_ready)
//   m_data     output byte (payload or CRC)
//   m_valid    output beat valid
//   m_last     marks the CRC beat, which ends the frame
//   m_ready    downstream accepts the beat
//   frame_cnt  (CRC8_FRAME_APPENDER_CNT_EN only) count of handshaken last
//              beats, 16-bit, wraps
//
// Optional feature macro: CRC8_FRAME_APPENDER_CNT_EN

// Combinational single-byte CRC-8 step, poly 0x07, MSB-first.
module crc (
  input  logic [7:0] crcIn,
  input  logic [7:0] data,
  output logic [7:0] crcOut
);

  always_comb begin
    logic [7:0] c;
    logic       fb;
    c = crcIn;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = c[7] ^ data[7 - i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    crcOut = c;
  end

endmodule

module crc8_frame_appender #(
  parameter logic [7:0] INIT    = 8'h00,
  parameter logic [7:0] XOR_OUT = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready
`ifdef CRC8_FRAME_APPENDER_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  typedef enum logic {
    PASS,
    APPEND
  } state_t;

  state_t     state;
  logic [7:0] crc_q;
  logic [7:0] crc_next;
  logic       slot_free;
  logic       accept;

  crc u_crc (
    .crcIn (crc_q),
    .data  (s_data),
    .crcOut(crc_next)
  );

  assign slot_free = !m_valid || m_ready;
  // Only m_ready reaches s_ready combinationally; s_valid never does.
  assign s_ready   = rst_n && (state == PASS) && slot_free;
  assign accept    = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= PASS;
      crc_q   <= INIT;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      case (state)
        PASS: begin
          if (accept) begin
            m_data  <= s_data;
            m_last  <= 1'b0;
            m_valid <= 1'b1;
            crc_q   <= crc_next;
            if (s_last) state <= APPEND;
          end else if (slot_free) begin
            m_valid <= 1'b0;
          end
        end
        APPEND: begin
          // Blocks input for one cycle while the CRC beat takes the slot.
          if (slot_free) begin
            m_data  <= crc_q ^ XOR_OUT;
            m_last  <= 1'b1;
            m_valid <= 1'b1;
            crc_q   <= INIT;
            state   <= PASS;
          end
        end
        default: state <= PASS;
      endcase
    end
  end

`ifdef CRC8_FRAME_APPENDER_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (m_valid && m_ready && m_last) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign frame_cnt = cnt_q;
`else
  // No frame counter in this build.
`endif

endmodule
